// File: rtl/multi_ch_idle_clk_gating.sv
// Multi-channel idle-hysteresis clock gating controller: one raw_clk, synchronised per-channel
// requests, an OFF/ON/HOLD hold-off FSM and a latch-based glitch-free gate on every channel.
module multi_ch_idle_clk_gating #(
   parameter int CH_NUM      = 4,
   parameter int STAGE_NUM   = 2,
   parameter int IDLE_CYCLES = 16
) (
   input  logic              raw_clk,
   input  logic              rst_n,
   input  logic [CH_NUM-1:0] active,
   input  logic [CH_NUM-1:0] bypass,
   input  logic              force_on,
   output logic [CH_NUM-1:0] gen_clk,
   output logic [CH_NUM-1:0] clk_on,
   output logic              all_idle
);

   localparam int CNT_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Reset synchroniser: asserts asynchronously, releases after STAGE_NUM edges.
   logic [STAGE_NUM-1:0] rst_sync_q;
   logic [STAGE_NUM-1:0] rst_sync_d;
   logic                 sync_rst_n;

   always_comb rst_sync_d = {rst_sync_q[STAGE_NUM-2:0], 1'b1};

   always_ff @(posedge raw_clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign sync_rst_n = rst_sync_q[STAGE_NUM-1];

   // force_on is merged before synchronisation so each channel sees one request bit.
   logic [CH_NUM-1:0] req;
   logic [CH_NUM-1:0] req_sync_q [STAGE_NUM];
   logic [CH_NUM-1:0] req_sync_d [STAGE_NUM];
   logic [CH_NUM-1:0] sreq;

   assign req = active | {CH_NUM{force_on}};

   always_comb begin
      req_sync_d[0] = req;
      for (int s = 1; s < STAGE_NUM; s++) begin
         req_sync_d[s] = req_sync_q[s-1];
      end
   end

   always_ff @(posedge raw_clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         for (int s = 0; s < STAGE_NUM; s++) begin
            req_sync_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < STAGE_NUM; s++) begin
            req_sync_q[s] <= req_sync_d[s];
         end
      end
   end

   assign sreq = req_sync_q[STAGE_NUM-1];

   logic [CH_NUM-1:0] en;
   logic [CH_NUM-1:0] off_d;

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      state_t           state_q;
      state_t           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             en_ch;
      logic             en_lat;

      always_ff @(posedge raw_clk or negedge sync_rst_n) begin
         if (!sync_rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            ST_OFF: begin
               if (sreq[gi]) begin
                  state_d = ST_ON;
               end
            end
            ST_ON: begin
               if (!sreq[gi]) begin
                  if (IDLE_CYCLES == 0) begin
                     state_d = ST_OFF;
                  end else begin
                     state_d = ST_HOLD;
                     cnt_d   = HOLD_INIT;
                  end
               end
            end
            ST_HOLD: begin
               // A returning request wins over an expiring count.
               if (sreq[gi]) begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end else if (cnt_q == '0) begin
                  state_d = ST_OFF;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         endcase
      end

      always_comb en_ch = (state_q != ST_OFF);

      assign en[gi]    = en_ch;
      assign off_d[gi] = (state_d == ST_OFF);

      // Transparent while raw_clk is low, so enable changes never cut a high phase short.
      always_latch begin
         if (!sync_rst_n) begin
            en_lat <= bypass[gi];
         end else if (!raw_clk) begin
            en_lat <= en_ch | bypass[gi];
         end
      end

      assign gen_clk[gi] = raw_clk & en_lat;
   end

   logic all_idle_q;
   logic all_idle_d;

   always_comb all_idle_d = &off_d;

   always_ff @(posedge raw_clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         all_idle_q <= 1'b1;
      end else begin
         all_idle_q <= all_idle_d;
      end
   end

   assign clk_on   = en;
   assign all_idle = all_idle_q;

endmodule
